bootrom_arbiter: RTL and testbench
==================================

Name: bootrom_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 8KB synchronous bootloader ROM (word-organised, read-only, one-cycle registered read latency).
- Port m0 is the CPU memory bus (valid/ready, picorv32 style); port m1 is a read-only secondary master, such as a boot-image CRC checker or debug reader.
- The block serialises accesses, drives the ROM enable and address, returns read data with a one-cycle ready pulse, and rejects writes with an error flag.

Parameters:
- ADDR_W, 13: byte address width into the ROM (8KB).
- FIXED_PRIO, 0: 0 = round-robin between m0/m1; 1 = m0 always wins ties.
- ERR_CNT_W, 8: width of the saturating write-error counter.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset
- m0_valid  input  1  CPU request; held with m0_addr/m0_wstrb until m0_ready
- m0_addr  input  ADDR_W  CPU byte address
- m0_wstrb  input  4  nonzero = write attempt
- m0_ready  output  1  one-cycle completion pulse to CPU
- m0_rdata  output  32  read data, valid when m0_ready=1
- m0_err  output  1  high with m0_ready when the request was a write
- m1_valid  input  1  secondary request; held with m1_addr until m1_ready
- m1_addr  input  ADDR_W  secondary byte address
- m1_ready  output  1  one-cycle completion pulse
- m1_rdata  output  32  read data, valid when m1_ready=1
- rom_addr  output  ADDR_W  ROM byte address (ROM uses bits [ADDR_W-1:2])
- rom_enable  output  1  ROM read strobe
- rom_rdata  input  32  ROM data, valid the cycle after rom_enable
- busy  output  1  high whenever state != IDLE
- wr_err_count  output  ERR_CNT_W  saturating count of rejected m0 writes

Behaviour:
- Reset is synchronous and active-low on resetn; clock is clk. All outputs are registered.
- Values under reset: state=IDLE, every output 0, last_grant=m1 (so m0 wins the first tie).
- States: IDLE, ISSUE, DATA, ACK.
- IDLE: arbitrate among asserted valids.
  - Both asserted: FIXED_PRIO=1 picks m0; FIXED_PRIO=0 picks the master that is not last_grant.
  - Winner: latch its address into rom_addr and record the grant, then go to ISSUE.
  - m0 winner with m0_wstrb!=0: skip the ROM and go straight to ACK with the error path. rom_enable stays 0.
- ISSUE: rom_enable=1 for exactly one cycle; rom_addr is stable. Next state DATA.
- DATA: rom_enable=0. At the end of the cycle, capture rom_rdata into the granted master's rdata register. Next state ACK.
- ACK: the granted master's ready=1 for exactly one cycle, with rdata valid.
  - Error path: m0_err=1 and m0_rdata=0. wr_err_count increments and saturates at 2^ERR_CNT_W-1.
  - last_grant is updated to the granted master.
  - Next state: if the other master has valid=1, grant it directly, going to ISSUE (or to ACK for the write-error path, m0 only). Otherwise go to IDLE.
  - The acked master's valid is ignored during ACK, because the requester drops it at that edge.
- Latency:
  - Read accepted in IDLE at edge N gives ready high during cycle N+3.
  - Rejected write gives ready during cycle N+1.
  - Back-to-back alternating masters complete one read every 3 cycles.
- Outside ACK, ready=0 and err=0. Each rdata register holds its last value until that master's next capture.
- rom_addr[1:0] are passed through and ignored by the ROM. Unaligned addresses return the containing word with no error.
- Valid dropped by a requester before its ready: protocol violation. The transaction completes anyway and the ready pulse is still issued.
- resetn low in any state: the same-edge return to IDLE. Any pending ready is lost; no partial pulse is emitted after reset.
- m1 has no write capability. wr_err_count counts only m0.

Test Plan:
- ROM word 1 = 0xDEADBEEF. m0_valid with m0_addr=0x0004 sampled at edge N -> rom_enable high in cycle N+1 only; m0_ready=1, m0_rdata=0xDEADBEEF, m0_err=0 in cycle N+3; busy high for cycles N+1..N+3.
- FIXED_PRIO=0, m0 and m1 continuously re-request (valid held, re-asserted after each ready) -> grants alternate m0,m1,m0,m1; one ready every 3 cycles; first grant is m0.
- FIXED_PRIO=1, both valid asserted in the same IDLE cycle -> m0 served first, m1 served directly after m0's ACK; m1_rdata = ROM word at m1_addr.
- m0_wstrb=4'hF, m0_addr=0x0010 -> rom_enable never asserted; m0_ready=1, m0_err=1, m0_rdata=0 one cycle after acceptance; wr_err_count 0->1. 300 such writes -> count saturates at 255.
- resetn driven low during DATA of an m1 read -> next cycle state IDLE, m1_ready=0, rom_enable=0, busy=0. After release, a new m0 request is served normally with 3-cycle latency.
- m0_addr=0x1FFE (unaligned, last word) with ROM word 2047=0x0000006F -> m0_rdata=0x0000006F, m0_err=0.

Source files
------------

// File: rtl/bootrom_arbiter.sv
// Two-master arbiter/sequencer in front of the synchronous boot ROM.
// Serialises m0/m1 reads, rejects m0 writes with an error pulse.
module bootrom_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int FIXED_PRIO = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m0_valid,
  input  logic [ADDR_W-1:0]    m0_addr,
  input  logic [3:0]           m0_wstrb,
  output logic                 m0_ready,
  output logic [31:0]          m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_valid,
  input  logic [ADDR_W-1:0]    m1_addr,
  output logic                 m1_ready,
  output logic [31:0]          m1_rdata,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 rom_enable,
  input  logic [31:0]          rom_rdata,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] wr_err_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA,
    ACK
  } state_t;

  localparam bit RR = (FIXED_PRIO == 0);

  state_t state;
  logic   grant;
  logic   last_grant;

  logic              pick_m1;
  logic              nxt_go;
  logic              nxt_m1;
  logic              nxt_wr;
  logic [ADDR_W-1:0] nxt_addr;

  always_comb begin
    pick_m1 = m1_valid;
    if (m0_valid && m1_valid)
      pick_m1 = RR ? ~last_grant : 1'b0;
  end

  // In ACK only the other master may be chained; the acked one is dropping valid.
  always_comb begin
    nxt_go = m0_valid | m1_valid;
    nxt_m1 = pick_m1;
    if (state == ACK) begin
      nxt_m1 = ~grant;
      nxt_go = grant ? m0_valid : m1_valid;
    end
    nxt_addr = nxt_m1 ? m1_addr : m0_addr;
    nxt_wr   = !nxt_m1 && (m0_wstrb != 4'h0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      m0_ready     <= 1'b0;
      m0_rdata     <= '0;
      m0_err       <= 1'b0;
      m1_ready     <= 1'b0;
      m1_rdata     <= '0;
      rom_addr     <= '0;
      rom_enable   <= 1'b0;
      busy         <= 1'b0;
      wr_err_count <= '0;
    end else begin
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      m0_err     <= 1'b0;
      rom_enable <= 1'b0;
      unique case (state)
        IDLE, ACK: begin
          if (state == ACK)
            last_grant <= grant;
          if (nxt_go) begin
            grant    <= nxt_m1;
            rom_addr <= nxt_addr;
            busy     <= 1'b1;
            if (nxt_wr) begin
              state    <= ACK;
              m0_ready <= 1'b1;
              m0_err   <= 1'b1;
              m0_rdata <= '0;
              if (wr_err_count != '1)
                wr_err_count <= wr_err_count + ERR_CNT_W'(1);
            end else begin
              state      <= ISSUE;
              rom_enable <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          state <= DATA;
        end
        DATA: begin
          state <= ACK;
          if (grant) begin
            m1_rdata <= rom_rdata;
            m1_ready <= 1'b1;
          end else begin
            m0_rdata <= rom_rdata;
            m0_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Bench for bootrom_arbiter: vector table, scoreboard on the round-robin
// instance, hand sequences for chaining, reset and fixed priority.
module tb_bootrom_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_valid = 1'b0;
  logic [12:0] m0_addr = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m1_valid = 1'b0;
  logic [12:0] m1_addr = '0;

  logic        a_m0_ready, a_m0_err, a_m1_ready, a_rom_enable, a_busy;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic [31:0] a_rom_rdata = '0;
  logic [12:0] a_rom_addr;
  logic [7:0]  a_wr_err_count;

  logic        b_m0_ready, b_m0_err, b_m1_ready, b_rom_enable, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic [31:0] b_rom_rdata = '0;
  logic [12:0] b_rom_addr;
  logic [7:0]  b_wr_err_count;

  bootrom_arbiter #(.ADDR_W(13), .FIXED_PRIO(0), .ERR_CNT_W(8)) u_a (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wstrb(m0_wstrb),
    .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr),
    .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
    .rom_addr(a_rom_addr), .rom_enable(a_rom_enable), .rom_rdata(a_rom_rdata),
    .busy(a_busy), .wr_err_count(a_wr_err_count)
  );

  bootrom_arbiter #(.ADDR_W(13), .FIXED_PRIO(1), .ERR_CNT_W(8)) u_b (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wstrb(m0_wstrb),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .rom_addr(b_rom_addr), .rom_enable(b_rom_enable), .rom_rdata(b_rom_rdata),
    .busy(b_busy), .wr_err_count(b_wr_err_count)
  );

  function automatic logic [31:0] rom_word(input int i);
    if (i == 1) return 32'hDEADBEEF;
    if (i == 2047) return 32'h0000006F;
    return (32'(i) * 32'h9E3779B1) + 32'h01234567;
  endfunction

  logic [31:0] mem [0:2047];
  initial for (int i = 0; i < 2048; i++) mem[i] = rom_word(i);

  always @(posedge clk) begin
    if (a_rom_enable) a_rom_rdata <= mem[a_rom_addr[12:2]];
    if (b_rom_enable) b_rom_rdata <= mem[b_rom_addr[12:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        m1;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb [$];
  exp_t e_m;

  always @(negedge clk) begin
    if (a_m0_ready || a_m1_ready) begin
      chk("dual_ready", 32'(a_m0_ready & a_m1_ready), 32'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e_m = sb.pop_front();
        chk("sb_master", 32'(a_m1_ready), 32'(e_m.m1));
        chk("sb_rdata", a_m1_ready ? a_m1_rdata : a_m0_rdata, e_m.d);
        chk("sb_err", 32'(a_m0_err), 32'(e_m.e));
      end
    end else begin
      chk("err_idle", 32'(a_m0_err), 32'd0);
    end
  end

  task automatic push(input logic m1, input logic [31:0] d, input logic e);
    exp_t t;
    t.m1 = m1;
    t.d  = d;
    t.e  = e;
    sb.push_back(t);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    m0_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic m0_req(input logic [12:0] addr, input logic [3:0] ws,
                        input logic [31:0] d, input int lat,
                        input logic [7:0] cnt);
    int n;
    logic [8:0] en;
    @(posedge clk);
    #1;
    m0_addr  = addr;
    m0_wstrb = ws;
    m0_valid = 1'b1;
    push(1'b0, d, ws != 4'h0);
    n  = 0;
    en = '0;
    do begin
      @(posedge clk);
      #1;
      n++;
      en[n] = a_rom_enable;
    end while (!a_m0_ready && n < 8);
    m0_valid = 1'b0;
    m0_wstrb = '0;
    chk("latency", 32'(n), 32'(lat));
    chk("rom_en_mask", 32'(en), (lat == 3) ? 32'h2 : 32'h0);
    chk("busy_ack", 32'(a_busy), 32'd1);
    @(posedge clk);
    #1;
    chk("busy_idle", 32'(a_busy), 32'd0);
    chk("err_cnt", 32'(a_wr_err_count), 32'(cnt));
  endtask

  typedef struct {
    logic [12:0] addr;
    logic [3:0]  ws;
    logic [31:0] d;
    int          lat;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, guard, prev, c0, nb, sat;

    tbl[0] = '{13'h0004, 4'h0, 32'hDEADBEEF,  3, 8'd0};
    tbl[1] = '{13'h0010, 4'hF, 32'h0,         1, 8'd1};
    tbl[2] = '{13'h1FFE, 4'h0, 32'h0000006F,  3, 8'd1};
    tbl[3] = '{13'h0000, 4'h0, rom_word(0),   3, 8'd1};
    tbl[4] = '{13'h0101, 4'h0, rom_word(64),  3, 8'd1};
    tbl[5] = '{13'h0004, 4'h1, 32'h0,         1, 8'd2};
    tbl[6] = '{13'h1000, 4'h0, rom_word(1024),3, 8'd2};
    tbl[7] = '{13'h1FFC, 4'h8, 32'h0,         1, 8'd3};

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_ready", 32'(a_m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(a_m1_ready), 32'd0);
    chk("rst_m0_err", 32'(a_m0_err), 32'd0);
    chk("rst_rom_en", 32'(a_rom_enable), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_cnt", 32'(a_wr_err_count), 32'd0);
    chk("rst_m0_rdata", a_m0_rdata, 32'd0);
    chk("rst_m1_rdata", a_m1_rdata, 32'd0);
    chk("rst_rom_addr", 32'(a_rom_addr), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++)
      m0_req(tbl[i].addr, tbl[i].ws, tbl[i].d, tbl[i].lat, tbl[i].cnt);

    // 300 rejected writes drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      sat = (4 + i > 255) ? 255 : 4 + i;
      m0_req(13'h0010, 4'hF, 32'h0, 1, 8'(sat));
    end
    chk("cnt_saturated", 32'(a_wr_err_count), 32'd255);

    // reset asserted while an m1 read sits in DATA
    @(posedge clk);
    #1;
    m1_addr  = 13'h0020;
    m1_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_issue_en", 32'(a_rom_enable), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_data_busy", 32'(a_busy), 32'd1);
    chk("mid_data_en", 32'(a_rom_enable), 32'd0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    m1_valid = 1'b0;
    chk("mid_rst_ready", 32'(a_m1_ready), 32'd0);
    chk("mid_rst_en", 32'(a_rom_enable), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_rdata", a_m1_rdata, 32'd0);
    chk("mid_rst_cnt", 32'(a_wr_err_count), 32'd0);
    resetn = 1'b1;
    m0_req(13'h0004, 4'h0, 32'hDEADBEEF, 3, 8'd0);

    // round-robin with both masters requesting continuously
    do_reset();
    m0_addr = 13'h0008;
    m1_addr = 13'h000C;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, rom_word(2), 1'b0);
      push(1'b1, rom_word(3), 1'b0);
    end
    @(posedge clk);
    #1;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    prev  = cyc;
    cnt   = 0;
    guard = 0;
    while (cnt < 6 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
      if (a_m0_ready || a_m1_ready) begin
        cnt++;
        chk("rr_gap", 32'(cyc - prev), 32'd3);
        prev = cyc;
        if (cnt == 6) begin
          m0_valid = 1'b0;
          m1_valid = 1'b0;
        end
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk("rr_count", 32'(cnt), 32'd6);
    @(posedge clk);
    #1;
    chk("rr_idle", 32'(a_busy), 32'd0);

    // tie after an m0 grant: round-robin picks m1, fixed priority picks m0
    do_reset();
    m0_req(13'h0008, 4'h0, rom_word(2), 3, 8'd0);
    push(1'b1, rom_word(6), 1'b0);
    push(1'b0, rom_word(5), 1'b0);
    @(posedge clk);
    #1;
    m0_addr  = 13'h0014;
    m1_addr  = 13'h0018;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    c0    = cyc;
    nb    = 0;
    guard = 0;
    while (nb < 2 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
      if (b_m0_ready || b_m1_ready) begin
        nb++;
        if (nb == 1) begin
          chk("fp_first_m0", 32'(b_m0_ready), 32'd1);
          chk("fp_first_data", b_m0_rdata, rom_word(5));
          chk("fp_first_time", 32'(cyc - c0), 32'd3);
        end else begin
          chk("fp_second_m1", 32'(b_m1_ready), 32'd1);
          chk("fp_second_data", b_m1_rdata, rom_word(6));
          chk("fp_second_time", 32'(cyc - c0), 32'd6);
          m0_valid = 1'b0;
          m1_valid = 1'b0;
        end
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk("fp_count", 32'(nb), 32'd2);
    @(posedge clk);
    #1;
    chk("fp_idle_b", 32'(b_busy), 32'd0);
    chk("fp_idle_a", 32'(a_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
